prv32_muldiv_seq: RTL and testbench
===================================

Name: prv32_muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide/remainder group.
- Replaces single-cycle combinational mul/div in the ALU path with an iterative shift-add / restoring-divide engine.
- Sits beside the execute-stage ALU; the decoder steers M-extension ops here; busy stalls the pipeline until done.

Parameters:
- XLEN, 32, operand and result width; iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when ready=1
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- flush  in  1  synchronous abort from pipeline kill
- ready  out  1  idle, can accept start
- busy  out  1  operation in flight; pipeline stall
- done  out  1  one-cycle result-valid pulse
- result  out  XLEN  registered result, held until next accept

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, all working registers 0.
  - result=0, done=0, busy=0, ready=1.
- States:
  - IDLE: ready=1, busy=0.
  - CALC: one iteration per cycle, counter 0..XLEN-1.
  - FIX: sign correction and result select.
  - DONE: done=1 for exactly one cycle, result valid.
- Accept: edge where state=IDLE, start=1, flush=0.
  - Latch funct3, sign flags, operand magnitudes.
  - Signed operand (MUL/MULH/DIV/REM: a and b; MULHSU: a only) is two's-complemented if bit XLEN-1=1.
  - Unsigned operands are taken raw.
- Transitions:
  - IDLE->CALC on accept; IDLE->FIX on accept when a fast-path condition holds.
  - CALC->FIX after XLEN iterations; FIX->DONE; DONE->IDLE.
- Fast paths, decided at accept, skip CALC:
  - Divide by zero (b=0): DIV/DIVU quotient=0xFFFFFFFF; REM/REMU remainder=a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV=0x80000000, REM=0.
- Multiply engine:
  - 2*XLEN product register; shift-add, one multiplier bit per CALC cycle.
  - FIX negates the 64-bit product when the operand signs differ (MULHSU: when a was negative).
  - MUL selects [31:0]; MULH/MULHSU/MULHU select [63:32].
- Divide engine:
  - Restoring, one quotient bit per cycle; remainder register XLEN+1 bits.
  - FIX: quotient negated if signs differ (DIV); remainder takes the sign of the dividend (REM).
- Latency, counted as edges after the accept edge to done visible:
  - Normal ops: XLEN+1 (33), i.e. XLEN CALC edges plus the FIX edge.
  - Fast path: 1.
- busy=1 from the accept edge until the edge leaving DONE.
- ready=0 in CALC/FIX/DONE; start is ignored there. No queueing, no back-to-back issue in DONE.
- result updates only on the FIX->DONE edge; it holds through IDLE until the next completion.
- Flush:
  - In any non-IDLE state, the next edge goes to IDLE: no done pulse, result unchanged, counter cleared.
  - start and flush in the same IDLE cycle: flush wins, nothing accepted.
- rst_n low mid-operation: immediate return to reset values; no done pulse.
- Operand inputs are don't-care after the accept edge.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done 33 cycles after accept, result=0xFFFFFFEB; busy high for those 33 cycles plus DONE.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIVU a=100, b=7 -> 14. REMU same operands -> 2.
- Corner cases, each done 1 cycle after accept:
  - DIVU a=5, b=0 -> 0xFFFFFFFF.
  - REM a=5, b=0 -> 5.
  - DIV a=0x80000000, b=-1 -> 0x80000000.
- Flush asserted at CALC iteration 10 -> state IDLE next edge, no done, result retains prior value. A new start the following cycle completes normally.
- rst_n pulsed low mid-CALC (between edges) -> busy=0, ready=1, result=0 immediately. start held during busy is ignored and does not queue a second op.

Source files
------------

// File: rtl/prv32_muldiv_seq.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | prv32_muldiv_seq: iterative RV32M mul/div/rem engine (shift-add, restoring)  |
// | rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
module prv32_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic            r_neg;
  logic            r_fast;
  logic [XLEN-1:0] r_fast_val;
  logic [XLEN-1:0] r_opb;
  logic [XLEN-1:0] r_lo;
  logic [XLEN:0]   r_hi;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_is_div;
  logic            w_div0;
  logic            w_ovf;
  logic            w_neg;
  logic [XLEN-1:0] w_fast_val;

  assign w_accept   = (r_state == S_IDLE) && start && !flush;
  // MULHU, DIVU and REMU are fully unsigned; MULHSU has only a signed rs1
  assign w_a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
  assign w_b_signed = w_a_signed && (funct3 != 3'b010);
  assign w_a_neg    = w_a_signed && a[XLEN-1];
  assign w_b_neg    = w_b_signed && b[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag    = w_b_neg ? (~b + 1'b1) : b;
  assign w_is_div   = funct3[2];
  assign w_div0     = w_is_div && (b == '0);
  assign w_ovf      = w_is_div && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  // REM takes the dividend sign; all other ops negate when operand signs differ
  assign w_neg      = (funct3[2] && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  always_comb begin
    w_fast_val = a;
    if (w_div0)
      w_fast_val = funct3[1] ? a : '1;
    else if (w_ovf)
      w_fast_val = funct3[1] ? '0 : a;
  end

  // Multiply step: product = {r_hi, r_lo}, r_lo doubles as the multiplier
  logic [XLEN:0]   w_sum;
  assign w_sum = r_hi + (r_lo[0] ? {1'b0, r_opb} : '0);

  // Divide step: r_hi is the partial remainder, r_lo shifts dividend out / quotient in
  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_q_bit;
  assign w_shift = {r_hi[XLEN-1:0], r_lo[XLEN-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_opb};
  assign w_q_bit = ~w_diff[XLEN+1];

  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_fix_res;

  assign w_prod   = {r_hi[XLEN-1:0], r_lo};
  assign w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_s  = r_neg ? (~r_lo + 1'b1) : r_lo;
  assign w_rem_s  = r_neg ? (~r_hi[XLEN-1:0] + 1'b1) : r_hi[XLEN-1:0];

  always_comb begin
    w_fix_res = w_prod_s[XLEN-1:0];
    if (r_fast) begin
      w_fix_res = r_fast_val;
    end else begin
      case (r_op)
        3'b000:                 w_fix_res = w_prod_s[XLEN-1:0];
        3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
        3'b100, 3'b101:         w_fix_res = w_quo_s;
        default:                w_fix_res = w_rem_s;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_neg      <= 1'b0;
      r_fast     <= 1'b0;
      r_fast_val <= '0;
      r_opb      <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_result   <= '0;
    end else if ((r_state != S_IDLE) && flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= funct3;
            r_neg      <= w_neg;
            r_fast     <= w_div0 || w_ovf;
            r_fast_val <= w_fast_val;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_opb      <= w_is_div ? w_b_mag : w_a_mag;
            r_lo       <= w_is_div ? w_a_mag : w_b_mag;
            r_state    <= (w_div0 || w_ovf) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (r_op[2]) begin
            r_hi <= w_q_bit ? w_diff[XLEN:0] : w_shift;
            r_lo <= {r_lo[XLEN-2:0], w_q_bit};
          end else begin
            r_hi <= {1'b0, w_sum[XLEN:1]};
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end
          if (r_cnt == CW'(XLEN - 1)) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready  = (r_state == S_IDLE);
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_prv32_muldiv_seq.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_prv32_muldiv_seq: directed self-checking bench for prv32_muldiv_seq       |
// | rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
module tb_prv32_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  prv32_muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] op_a,
                        input logic [31:0] op_b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bit busy_lost;
    bit got_done;
    @(negedge clk);
    check_val({tag, "_ready"}, {31'b0, ready}, 32'd1);
    start = 1'b1; funct3 = f3; a = op_a; b = op_b;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0; busy_lost = !busy; got_done = 1'b0;
    while (!got_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_lost = 1'b1;
      if (done) got_done = 1'b1;
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_res"}, result, exp_res);
    check_val({tag, "_busy"}, {31'b0, busy_lost}, 32'd0);
    @(posedge clk); #1;
    check_val({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int  lat;
    bit  saw_done;
    rst_n = 1'b0; start = 1'b0; funct3 = 3'b000; a = '0; b = '0; flush = 1'b0;
    #1;
    check_val("rst_ready", {31'b0, ready}, 32'd1);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul_7_m3",   3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mul_lo",     3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
    run_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
    run_op("divu_100_7", 3'b101, 32'd100,      32'd7,        32'd14,        33);
    run_op("remu_100_7", 3'b111, 32'd100,      32'd7,        32'd2,         33);
    run_op("divu_by0",   3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    run_op("rem_by0",    3'b110, 32'd5,        32'd0,        32'd5,         1);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1);
    run_op("divu_seed",  3'b101, 32'd100,      32'd7,        32'd14,        33);

    // Flush at CALC iteration 10: no done pulse, prior result kept
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_val("flush_ready", {31'b0, ready}, 32'd1);
    check_val("flush_busy", {31'b0, busy}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check_val("flush_nodone", {31'b0, saw_done}, 32'd0);
    check_val("flush_result", result, 32'd14);
    run_op("after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 33);

    // start held high through the whole operation is not queued
    @(negedge clk);
    start = 1'b1; funct3 = 3'b111; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    lat = 0; saw_done = 1'b0;
    while (!saw_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) saw_done = 1'b1;
    end
    start = 1'b0;
    check_val("hold_lat", lat, 33);
    check_val("hold_res", result, 32'd2);
    @(posedge clk); #1;
    check_val("hold_idle1", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    check_val("hold_idle2", {30'b0, busy, done}, 32'd0);

    // Asynchronous reset between edges mid-CALC
    @(negedge clk);
    start = 1'b1; funct3 = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", {31'b0, busy}, 32'd0);
    check_val("arst_ready", {31'b0, ready}, 32'd1);
    check_val("arst_result", result, 32'h0);
    check_val("arst_done", {31'b0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
